// File: rtl/line_memory_responder_if.sv
// -----------------------------------------------------------------------------
// line_memory_responder_if
// Purpose : Cache-line memory bus between a cache (initiator) and the line
//           memory responder. A request is a level held on mem_read/mem_write
//           until a one-cycle mem_ready pulse marks completion.
// Signals :
//   mem_read   initiator -> memory  1    line read request
//   mem_write  initiator -> memory  1    line write request
//   mem_addr   initiator -> memory  28   line address (word address >> 2)
//   mem_wdata  initiator -> memory  128  write line, word 0 in [31:0]
//   mem_rdata  memory -> initiator  128  read line, word 0 in [31:0]
//   mem_ready  memory -> initiator  1    one-cycle completion pulse
// Modports: master (cache side), slave (memory side)
// -----------------------------------------------------------------------------
interface line_memory_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/line_memory_responder.sv
// -----------------------------------------------------------------------------
// line_memory_responder
// Purpose : Backing store for the I-/D-cache. Serves one 128-bit line read or
//           write at a time out of an internal line array. Completion comes a
//           fixed LATENCY cycles after the request is accepted, signalled by a
//           single-cycle mem_ready pulse.
// Parameters:
//   LATENCY     cycles from the accepting edge to the mem_ready cycle (1..255)
//   DEPTH_LOG2  log2 of the line count; the line index is the low DEPTH_LOG2
//               bits of mem_addr and the upper bits alias
// Ports   :
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset, also clears the line array
//   mem    slave side of line_memory_responder_if
// -----------------------------------------------------------------------------
module line_memory_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  line_memory_responder_if.slave mem
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0]  LOAD  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_count;
  logic                  r_isWrite;
  logic [DEPTH_LOG2-1:0] r_index;
  logic [127:0]          r_wdata;
  logic [127:0]          r_lines [DEPTH];
  logic [127:0]          r_rdata;
  logic                  r_ready;
  logic                  w_request;
  logic                  w_accept;
  logic                  w_enterResp;
  logic                  w_unusedAddrBits;

  assign w_request   = mem.mem_read | mem.mem_write;
  assign w_accept    = (r_state == IDLE) && w_request;
  // The counter is loaded with LATENCY-1 on accept and reaches zero on the
  // edge before the one that enters RESP, which puts mem_ready exactly
  // LATENCY edges after acceptance for every legal LATENCY, including 1.
  assign w_enterResp = (r_state == WAIT) && (r_count == 8'd0);

  // Address bits above the index are ignored on purpose (aliasing).
  assign w_unusedAddrBits = ^mem.mem_addr[27:DEPTH_LOG2];

  // State register; an async reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so a request still
  // held during RESP is ignored, and dropping it during WAIT does not abort.
  // The unused encoding falls back to IDLE.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_request ? WAIT : IDLE;
      WAIT:    w_next = (r_count == 8'd0) ? RESP : WAIT;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture and latency countdown. Write wins when both request lines
  // are high, so the op bit is simply mem_write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 8'd0;
      r_isWrite <= 1'b0;
      r_index   <= '0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_count   <= LOAD;
      r_isWrite <= mem.mem_write;
      r_index   <= mem.mem_addr[DEPTH_LOG2-1:0];
      r_wdata   <= mem.mem_wdata;
    end else if ((r_state == WAIT) && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  // Line array. A write commits at the edge entering RESP, so any read
  // accepted afterwards already sees the new line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_lines[i] <= '0;
      end
    end else if (w_enterResp && r_isWrite) begin
      r_lines[r_index] <= r_wdata;
    end
  end

  // Registered response. Read data is loaded on the edge entering RESP and
  // then held until the next read; mem_ready is high only in the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_next == RESP);
      if (w_enterResp && !r_isWrite) begin
        r_rdata <= r_lines[r_index];
      end
    end
  end

  assign mem.mem_rdata = r_rdata;
  assign mem.mem_ready = r_ready;

endmodule

// File: tb/tb_line_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_line_memory_responder
// Purpose : Self-checking bench for line_memory_responder. Directed steps and a
//           randomized phase are compared against a plain array model of the
//           line store plus the expected completion latency.
// -----------------------------------------------------------------------------
module tb_line_memory_responder;

  localparam int LATENCY    = 4;
  localparam int DEPTH_LOG2 = 6;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk;
  logic rst_n;

  line_memory_responder_if memIf ();

  line_memory_responder #(
    .LATENCY    (LATENCY),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (memIf)
  );

  // Reference model: what each line should hold and what mem_rdata should show.
  logic [127:0] modelLines [DEPTH];
  logic [127:0] modelRdata;
  int           errors;
  int           checks;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Clears the model exactly as a reset clears the design.
  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) modelLines[i] = '0;
    modelRdata = '0;
  endtask

  // One complete transaction as a well-behaved initiator: raise the request,
  // wait (bounded) for mem_ready, drop the request as soon as it is seen, then
  // check latency, returned data and that the pulse lasts one cycle.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [27:0] addr, input logic [127:0] wdata);
    int seenAt;
    int idx;
    idx = int'(addr) % DEPTH;
    @(negedge clk);
    memIf.mem_read  = rd;
    memIf.mem_write = wr;
    memIf.mem_addr  = addr;
    memIf.mem_wdata = wdata;
    seenAt = -1;
    for (int k = 0; k <= LATENCY + 4 && seenAt < 0; k++) begin
      @(posedge clk);
      #1;
      if (memIf.mem_ready === 1'b1) seenAt = k;
    end
    memIf.mem_read  = 1'b0;
    memIf.mem_write = 1'b0;
    checkOutput({tag, " latency"}, 128'(seenAt), 128'(LATENCY));
    if (wr) begin
      modelLines[idx] = wdata;
    end else if (rd) begin
      modelRdata = modelLines[idx];
    end
    if (seenAt >= 0) begin
      checkOutput({tag, " rdata"}, memIf.mem_rdata, modelRdata);
      @(posedge clk);
      #1;
      checkOutput({tag, " ready width"}, 128'(memIf.mem_ready), 128'(0));
    end
  endtask

  initial begin
    int pulses;
    int firstAt;
    int secondAt;
    logic [127:0] lineA;
    logic [127:0] lineB;
    logic [31:0]  upper;
    int           op;
    int           idx;

    errors = 0;
    checks = 0;
    memIf.mem_read  = 1'b0;
    memIf.mem_write = 1'b0;
    memIf.mem_addr  = '0;
    memIf.mem_wdata = '0;
    clearModel();

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ready", 128'(memIf.mem_ready), 128'(0));
    checkOutput("reset rdata", memIf.mem_rdata, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read of a never-written line returns zero after the full latency.
    applyStimulus("read cleared", 1'b1, 1'b0, 28'h0000005, 128'h0);

    // Write then read back; word 0 sits in the low 32 bits and is held after.
    lineA = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    applyStimulus("write idx3", 1'b0, 1'b1, 28'h0000003, lineA);
    applyStimulus("read idx3", 1'b1, 1'b0, 28'h0000003, 128'h0);
    @(negedge clk);
    checkOutput("word0 held", 128'(memIf.mem_rdata[31:0]), 128'(32'hAAAAAAAA));

    // Upper address bits alias onto the same line.
    lineB = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    applyStimulus("write alias", 1'b0, 1'b1, 28'h0000042, lineB);
    applyStimulus("read alias", 1'b1, 1'b0, 28'h0000002, 128'h0);

    // Read held high across RESP: exactly two pulses, the second one a full
    // latency after the first IDLE edge that follows RESP.
    @(negedge clk);
    memIf.mem_read = 1'b1;
    memIf.mem_addr = 28'h0000003;
    @(posedge clk);
    pulses = 0;
    firstAt = -1;
    secondAt = -1;
    for (int k = 1; k <= 2 * LATENCY + 4; k++) begin
      @(posedge clk);
      #1;
      if (memIf.mem_ready === 1'b1) begin
        pulses++;
        if (firstAt < 0) firstAt = k;
        else secondAt = k;
        checkOutput("held read rdata", memIf.mem_rdata, lineA);
      end
      if (k == 2 * LATENCY + 2) memIf.mem_read = 1'b0;
    end
    memIf.mem_read = 1'b0;
    modelRdata = lineA;
    checkOutput("held read pulses", 128'(pulses), 128'(2));
    checkOutput("held read first", 128'(firstAt), 128'(LATENCY));
    checkOutput("held read second", 128'(secondAt), 128'(2 * LATENCY + 2));

    // Read and write together: the write wins and rdata keeps its old value.
    applyStimulus("both high", 1'b1, 1'b1, 28'h0000007, 128'hCAFE_F00D);
    applyStimulus("read both", 1'b1, 1'b0, 28'h0000007, 128'h0);

    // Reset two cycles into the wait of a write: no pulse, write discarded.
    @(negedge clk);
    memIf.mem_write = 1'b1;
    memIf.mem_addr  = 28'h0000009;
    memIf.mem_wdata = 128'h5555_AAAA_5555_AAAA;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    memIf.mem_write = 1'b0;
    clearModel();
    #1;
    checkOutput("abort ready", 128'(memIf.mem_ready), 128'(0));
    checkOutput("abort rdata", memIf.mem_rdata, 128'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("abort ready held", 128'(memIf.mem_ready), 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("read aborted", 1'b1, 1'b0, 28'h0000009, 128'h0);
    applyStimulus("read cleared3", 1'b1, 1'b0, 28'h0000003, 128'h0);

    // Randomized mix of reads, writes and combined requests over a few lines
    // with random upper address bits to exercise aliasing.
    for (int n = 0; n < 24; n++) begin
      op    = int'($urandom_range(0, 2));
      idx   = int'($urandom_range(0, 7));
      upper = $urandom;
      applyStimulus("random", (op != 1), (op != 0),
                    {upper[21:0], 6'(idx)},
                    {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
